// File: rtl/lms_stream_sched.sv
// Sample-tick scheduler for the LMS noise canceller: primes and pairs the audio/UDP FIFO reads,
// handles underrun stalls and weight flushes. Define LMS_SKEW_CORR_EN to enable one-sample skew drops.
module lms_stream_sched #(
    parameter int LEVEL_W       = 11,
    parameter int PRIME_LEVEL   = 64,
    parameter int RESUME_LEVEL  = 16,
    parameter int SKEW_MAX      = 32,
    parameter int STALL_TIMEOUT = 4096,
    parameter int CNT_W         = 16
) (
    input  logic               audio_clk,
    input  logic               audio_rst,
    input  logic               start,
    input  logic               sample_tick,
    input  logic               aud_empty,
    input  logic [LEVEL_W-1:0] aud_level,
    input  logic               udp_empty,
    input  logic [LEVEL_W-1:0] udp_level,
    output logic               aud_rd_en,
    output logic               udp_rd_en,
    output logic               lms_en,
    output logic               lms_clr,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   underrun_cnt,
    output logic [CNT_W-1:0]   drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_RUN   = 3'd2,
        S_STALL = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    // Levels are compared with two guard bits so level + SKEW_MAX cannot overflow.
    localparam int EXT_W = LEVEL_W + 2;
    localparam int TMR_W = $clog2(STALL_TIMEOUT) + 1;

    localparam logic [EXT_W-1:0] PRIME_L  = EXT_W'(PRIME_LEVEL);
    localparam logic [EXT_W-1:0] RESUME_L = EXT_W'(RESUME_LEVEL);
    localparam logic [EXT_W-1:0] SKEW_L   = EXT_W'(SKEW_MAX);
    localparam logic [EXT_W-1:0] TWO_L    = EXT_W'(2);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STALL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

`ifdef LMS_SKEW_CORR_EN
    localparam bit SKEW_EN = 1'b1;
`else
    localparam bit SKEW_EN = 1'b0;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_aud_rd;
    logic             r_udp_rd;
    logic             r_drop_aud;
    logic             r_drop_udp;
    logic             r_lms_en;
    logic             r_lms_clr;
    logic [TMR_W-1:0] r_timer;
    logic [CNT_W-1:0] r_underrun_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [EXT_W-1:0] w_aud_ext;
    logic [EXT_W-1:0] w_udp_ext;
    logic             w_primed;
    logic             w_resumed;
    logic             w_fifo_ok;
    logic             w_busy;
    logic             w_tick_ok;
    logic             w_skew_aud;
    logic             w_skew_udp;
    logic             w_aud_rd_nxt;
    logic             w_udp_rd_nxt;
    logic             w_drop_aud_nxt;
    logic             w_drop_udp_nxt;
    logic             w_underrun_inc;
    logic             w_drop_inc;
    logic             w_clr_nxt;
    logic [TMR_W-1:0] w_timer_nxt;

    assign w_aud_ext = {2'b00, aud_level};
    assign w_udp_ext = {2'b00, udp_level};
    assign w_primed  = (w_aud_ext >= PRIME_L)  && (w_udp_ext >= PRIME_L);
    assign w_resumed = (w_aud_ext >= RESUME_L) && (w_udp_ext >= RESUME_L);
    assign w_fifo_ok = !aud_empty && !udp_empty;

    // Busy from the paired strobe until any trailing drop strobe has been issued.
    assign w_busy    = r_aud_rd || r_udp_rd || r_drop_aud || r_drop_udp;
    assign w_tick_ok = (r_state == S_RUN) && sample_tick && !w_busy;

    // The drop needs a second word behind the paired one, hence the >= 2 guard.
    assign w_skew_udp = SKEW_EN && (w_udp_ext > w_aud_ext + SKEW_L) && (w_udp_ext >= TWO_L);
    assign w_skew_aud = SKEW_EN && (w_aud_ext > w_udp_ext + SKEW_L) && (w_aud_ext >= TWO_L);

    always_ff @(posedge audio_clk or posedge audio_rst) begin
        if (audio_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        w_state_nxt    = r_state;
        w_aud_rd_nxt   = 1'b0;
        w_udp_rd_nxt   = 1'b0;
        w_drop_aud_nxt = 1'b0;
        w_drop_udp_nxt = 1'b0;
        w_underrun_inc = 1'b0;
        w_drop_inc     = 1'b0;
        w_timer_nxt    = '0;

        // A drop queued by the previous tick always completes, whatever the state does.
        if (r_drop_aud) begin
            w_aud_rd_nxt = 1'b1;
            w_drop_inc   = 1'b1;
        end
        if (r_drop_udp) begin
            w_udp_rd_nxt = 1'b1;
            w_drop_inc   = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_PRIME;
            end
            S_PRIME: begin
                if (!start)        w_state_nxt = S_IDLE;
                else if (w_primed) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_tick_ok) begin
                    if (w_fifo_ok) begin
                        w_aud_rd_nxt   = 1'b1;
                        w_udp_rd_nxt   = 1'b1;
                        w_drop_aud_nxt = w_skew_aud;
                        w_drop_udp_nxt = w_skew_udp;
                    end else begin
                        w_underrun_inc = 1'b1;
                        w_state_nxt    = start ? S_STALL : S_IDLE;
                    end
                end else if (!start && !w_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_STALL: begin
                if (!start)                   w_state_nxt = S_IDLE;
                else if (r_timer == TMR_LAST) w_state_nxt = S_FLUSH;
                else if (w_resumed)           w_state_nxt = S_RUN;
                else                          w_timer_nxt = r_timer + 1'b1;
            end
            S_FLUSH: begin
                w_state_nxt = S_PRIME;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_clr_nxt = (w_state_nxt == S_FLUSH);

    always_ff @(posedge audio_clk or posedge audio_rst) begin
        if (audio_rst) begin
            r_aud_rd       <= 1'b0;
            r_udp_rd       <= 1'b0;
            r_drop_aud     <= 1'b0;
            r_drop_udp     <= 1'b0;
            r_lms_en       <= 1'b0;
            r_lms_clr      <= 1'b0;
            r_timer        <= '0;
            r_underrun_cnt <= '0;
            r_drop_cnt     <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
            r_aud_rd   <= w_aud_rd_nxt;
            r_udp_rd   <= w_udp_rd_nxt;
            r_drop_aud <= w_drop_aud_nxt;
            r_drop_udp <= w_drop_udp_nxt;
            r_lms_en   <= r_aud_rd && r_udp_rd;
            r_lms_clr  <= w_clr_nxt;
            r_timer    <= w_timer_nxt;
            if (w_underrun_inc && (r_underrun_cnt != CNT_MAX)) begin
                r_underrun_cnt <= r_underrun_cnt + 1'b1;
            end
            if (w_drop_inc && (r_drop_cnt != CNT_MAX)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign aud_rd_en    = r_aud_rd;
    assign udp_rd_en    = r_udp_rd;
    assign lms_en       = r_lms_en;
    assign lms_clr      = r_lms_clr;
    assign state        = r_state;
    assign underrun_cnt = r_underrun_cnt;
    assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_lms_stream_sched.sv
// Bench for lms_stream_sched: a cycle-indexed event-schedule model is compared against every output
// each cycle, plus directed literal checks for priming, underrun, timeout flush, skew drop and reset.
module tb_lms_stream_sched;

    logic        audio_clk   = 1'b0;
    logic        audio_rst   = 1'b0;
    logic        start       = 1'b0;
    logic        sample_tick = 1'b0;
    logic        aud_empty   = 1'b1;
    logic        udp_empty   = 1'b1;
    logic [10:0] aud_level   = '0;
    logic [10:0] udp_level   = '0;
    logic        aud_rd_en;
    logic        udp_rd_en;
    logic        lms_en;
    logic        lms_clr;
    logic [2:0]  state;
    logic [15:0] underrun_cnt;
    logic [15:0] drop_cnt;

`ifdef LMS_SKEW_CORR_EN
    localparam bit TB_SKEW = 1'b1;
`else
    localparam bit TB_SKEW = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int n_pair = 0, n_lms = 0, n_clr = 0, n_usingle = 0, n_asingle = 0;
    int n, snap_pair, snap_lms, snap_us, rnd_a, rnd_u;

    lms_stream_sched dut (
        .audio_clk   (audio_clk),
        .audio_rst   (audio_rst),
        .start       (start),
        .sample_tick (sample_tick),
        .aud_empty   (aud_empty),
        .aud_level   (aud_level),
        .udp_empty   (udp_empty),
        .udp_level   (udp_level),
        .aud_rd_en   (aud_rd_en),
        .udp_rd_en   (udp_rd_en),
        .lms_en      (lms_en),
        .lms_clr     (lms_clr),
        .state       (state),
        .underrun_cnt(underrun_cnt),
        .drop_cnt    (drop_cnt)
    );

    initial forever #5 audio_clk = ~audio_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Served ticks schedule their strobes into per-edge event maps; outputs are read from those maps.
    int          m_edge = 0;
    int          m_state, m_timer, m_last;
    logic [15:0] m_under, m_drop;
    bit          m_clr;
    bit          sch_pair[int];
    bit          sch_lms[int];
    bit          sch_aud1[int];
    bit          sch_udp1[int];
    bit          sch_dinc[int];

    task automatic model_clear();
        m_state = 0;
        m_timer = 0;
        m_last  = -1000000;
        m_under = '0;
        m_drop  = '0;
        m_clr   = 1'b0;
        sch_pair.delete();
        sch_lms.delete();
        sch_aud1.delete();
        sch_udp1.delete();
        sch_dinc.delete();
    endtask

    task automatic model_step(input int e);
        int nxt  = m_state;
        bit free = (e - 1 > m_last);
        int al   = int'(aud_level);
        int ul   = int'(udp_level);
        if (sch_dinc.exists(e) && m_drop != 16'hFFFF) m_drop++;
        case (m_state)
            0: if (start) nxt = 1;
            1: if (!start) nxt = 0; else if (al >= 64 && ul >= 64) nxt = 2;
            2: begin
                if (sample_tick && free) begin
                    if (!aud_empty && !udp_empty) begin
                        sch_pair[e]  = 1'b1;
                        sch_lms[e+1] = 1'b1;
                        m_last       = e;
                        if (TB_SKEW && ul > al + 32 && ul >= 2) begin
                            sch_udp1[e+1] = 1'b1;
                            sch_dinc[e+1] = 1'b1;
                            m_last        = e + 1;
                        end else if (TB_SKEW && al > ul + 32 && al >= 2) begin
                            sch_aud1[e+1] = 1'b1;
                            sch_dinc[e+1] = 1'b1;
                            m_last        = e + 1;
                        end
                    end else begin
                        if (m_under != 16'hFFFF) m_under++;
                        nxt = start ? 3 : 0;
                    end
                end else if (!start && free) begin
                    nxt = 0;
                end
            end
            3: begin
                if (!start)                   nxt = 0;
                else if (m_timer == 4095)     nxt = 4;
                else if (al >= 16 && ul >= 16) nxt = 2;
            end
            4: nxt = 1;
            default: nxt = 0;
        endcase
        m_timer = (m_state == 3 && nxt == 3) ? m_timer + 1 : 0;
        m_clr   = (nxt == 4);
        m_state = nxt;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge audio_clk or posedge audio_rst);
            if (audio_rst) model_clear();
            else begin
                m_edge++;
                model_step(m_edge);
            end
        end
    end

    // Per-cycle compare and pulse counting, away from the active edge.
    initial forever begin
        @(negedge audio_clk);
        check("aud_rd_en", 32'(aud_rd_en), 32'(sch_pair.exists(m_edge) || sch_aud1.exists(m_edge)));
        check("udp_rd_en", 32'(udp_rd_en), 32'(sch_pair.exists(m_edge) || sch_udp1.exists(m_edge)));
        check("lms_en", 32'(lms_en), 32'(sch_lms.exists(m_edge)));
        check("lms_clr", 32'(lms_clr), 32'(m_clr));
        check("state", 32'(state), 32'(m_state));
        check("underrun_cnt", 32'(underrun_cnt), 32'(m_under));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (aud_rd_en && udp_rd_en) n_pair++;
        if (aud_rd_en && !udp_rd_en) n_asingle++;
        if (udp_rd_en && !aud_rd_en) n_usingle++;
        if (lms_en) n_lms++;
        if (lms_clr) n_clr++;
    end

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge audio_clk);
            #1;
        end
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 audio_rst = 1'b1;
        cyc(3);
        check("rst_state", 32'(state), 0);
        check("rst_underrun", 32'(underrun_cnt), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        check("rst_strobes", 32'({aud_rd_en, udp_rd_en, lms_en, lms_clr}), 0);
        audio_rst = 1'b0;

        // Priming: levels ramp to 63 keep PRIME, 64 enters RUN next cycle.
        start = 1'b1; aud_empty = 1'b0; udp_empty = 1'b0;
        for (int l = 0; l < 64; l++) begin
            aud_level = 11'(l); udp_level = 11'(l);
            cyc(1);
        end
        check("prime_hold", 32'(state), 1);
        aud_level = 11'd64; udp_level = 11'd64;
        cyc(1);
        check("prime_to_run", 32'(state), 2);
        check("model_run", 32'(m_state), 2);

        // First tick: rd_en at +1, lms_en at +2.
        check("pre_tick_rd", 32'(aud_rd_en | udp_rd_en), 0);
        tick();
        check("tick_rd_pair", 32'({aud_rd_en, udp_rd_en, lms_en}), 32'h6);
        cyc(1);
        check("tick_lms", 32'({aud_rd_en, udp_rd_en, lms_en}), 32'h1);
        cyc(1);
        check("tick_done", 32'({aud_rd_en, udp_rd_en, lms_en}), 32'h0);

        // Steady run: 100 ticks, spacing 8.
        aud_level = 11'd200; udp_level = 11'd200;
        cyc(4);
        n_pair = 0; n_lms = 0;
        repeat (100) begin
            tick();
            cyc(7);
        end
        check("steady_pairs", 32'(n_pair), 100);
        check("steady_lms", 32'(n_lms), 100);
        check("steady_underrun", 32'(underrun_cnt), 0);
        check("steady_drop", 32'(drop_cnt), 0);

        // Underrun then resume at 16/16 without a flush.
        udp_level = 11'd0; udp_empty = 1'b1;
        tick();
        check("underrun_state", 32'(state), 3);
        check("underrun_cnt1", 32'(underrun_cnt), 1);
        check("underrun_no_rd", 32'(aud_rd_en | udp_rd_en), 0);
        cyc(5);
        check("stall_hold", 32'(state), 3);
        aud_level = 11'd16; udp_level = 11'd16; udp_empty = 1'b0;
        cyc(1);
        check("resume_run", 32'(state), 2);
        check("resume_no_clr", 32'(n_clr), 0);

        // Timeout: 4096 cycles in STALL, one lms_clr, then PRIME.
        udp_level = 11'd0; udp_empty = 1'b1;
        tick();
        check("timeout_stall", 32'(state), 3);
        check("underrun_cnt2", 32'(underrun_cnt), 2);
        n = 0;
        while (state != 3'd4 && n < 5000) begin
            cyc(1);
            n++;
        end
        check("flush_cycles", 32'(n), 4096);
        check("flush_clr", 32'(lms_clr), 1);
        cyc(1);
        check("flush_to_prime", 32'(state), 1);
        check("flush_clr_off", 32'(lms_clr), 0);
        cyc(4);
        check("flush_clr_count", 32'(n_clr), 1);

        // Skew: aud=100, udp=140.
        aud_level = 11'd100; udp_level = 11'd140; aud_empty = 1'b0; udp_empty = 1'b0;
        cyc(1);
        check("skew_run", 32'(state), 2);
        cyc(3);
        snap_pair = n_pair; snap_lms = n_lms; snap_us = n_usingle;
        tick();
        check("skew_pair", 32'({aud_rd_en, udp_rd_en, lms_en}), 32'h6);
        cyc(1);
        check("skew_drop_strobe", 32'({aud_rd_en, udp_rd_en, lms_en}), 32'({1'b0, TB_SKEW, 1'b1}));
        cyc(1);
        check("skew_after", 32'({aud_rd_en, udp_rd_en, lms_en}), 32'h0);
        cyc(2);
        check("skew_drop_cnt", 32'(drop_cnt), 32'(TB_SKEW));
        check("skew_pairs", 32'(n_pair - snap_pair), 1);
        check("skew_lms", 32'(n_lms - snap_lms), 1);
        check("skew_singles", 32'(n_usingle - snap_us), 32'(TB_SKEW));

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 400; i++) begin
            rnd_a = int'($urandom_range(0, 300));
            rnd_u = rnd_a + int'($urandom_range(0, 100)) - 50;
            if (rnd_u < 0) rnd_u = 0;
            aud_level = 11'(rnd_a);
            udp_level = 11'(rnd_u);
            aud_empty = (rnd_a == 0) || ($urandom_range(0, 15) == 0);
            udp_empty = (rnd_u == 0) || ($urandom_range(0, 15) == 0);
            start     = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 3) != 0) tick();
            else cyc(1);
            cyc(int'($urandom_range(3, 9)));
        end

        // Reset in the cycle the paired read is high.
        start = 1'b1; aud_level = 11'd200; udp_level = 11'd200;
        aud_empty = 1'b0; udp_empty = 1'b0;
        n = 0;
        while (state != 3'd2 && n < 50) begin
            cyc(1);
            n++;
        end
        check("mid_rst_run", 32'(state), 2);
        cyc(4);
        tick();
        check("mid_rst_pair", 32'(aud_rd_en & udp_rd_en), 1);
        #2 audio_rst = 1'b1;
        #1;
        check("mid_rst_outputs", 32'({aud_rd_en, udp_rd_en, lms_en, lms_clr}), 0);
        check("mid_rst_state", 32'(state), 0);
        check("mid_rst_cnts", 32'({underrun_cnt, drop_cnt}), 0);
        start = 1'b0;
        snap_lms = n_lms;
        cyc(2);
        audio_rst = 1'b0;
        cyc(5);
        check("mid_rst_no_lms", 32'(n_lms - snap_lms), 0);
        check("mid_rst_idle", 32'(state), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lms_stream_sched.md
Name: lms_stream_sched

Overview:
- Scheduler for the adaptive noise-cancellation LMS datapath.
- Sequences paired reads from the microphone-audio FIFO and the UDP reference FIFO, one pair per audio sample tick, and drives the LMS enable.
- Primes both FIFOs before running and handles underrun stalls.
- Resets the LMS weights after a long stall, and corrects slow rate drift between the two streams by dropping single samples.

Parameters:
- LEVEL_W, 11, width of the FIFO read-side water-level inputs.
- PRIME_LEVEL, 64, words required in both FIFOs before RUN is entered.
- RESUME_LEVEL, 16, words required in both FIFOs to leave STALL.
- SKEW_MAX, 32, level difference (words) that triggers a one-sample drop.
- STALL_TIMEOUT, 4096, cycles in STALL before LMS weights are flushed.
- CNT_W, 16, width of the status counters.

Ports:
- audio_clk  in  1  sole clock; LMS and both FIFO read sides run on it.
- audio_rst  in  1  asynchronous, active-high reset.
- start  in  1  level; 1 = run cancellation, 0 = stop.
- sample_tick  in  1  one-cycle pulse per audio sample.
- aud_empty  in  1  audio FIFO empty.
- aud_level  in  LEVEL_W  audio FIFO read water level.
- udp_empty  in  1  UDP FIFO empty.
- udp_level  in  LEVEL_W  UDP FIFO read water level.
- aud_rd_en  out  1  audio FIFO read strobe.
- udp_rd_en  out  1  UDP FIFO read strobe.
- lms_en  out  1  LMS enable; data valid on FIFO outputs this cycle.
- lms_clr  out  1  one-cycle pulse that clears the LMS weights/delay line.
- state  out  3  current FSM state (encoding below).
- underrun_cnt  out  CNT_W  saturating count of ticks lost to empty FIFOs.
- drop_cnt  out  CNT_W  saturating count of skew-correction drops.

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - All outputs 0; state = IDLE; counters 0; timer 0; no read pending.
- All outputs are registered.
- FIFO read latency is 1 cycle. lms_en is the paired read strobe delayed 1 cycle, so LMS total latency is tick -> rd_en at +1 cycle -> lms_en at +2 cycles.
- State encoding: IDLE=0, PRIME=1, RUN=2, STALL=3, FLUSH=4.
- IDLE:
  - No reads.
  - start=1 -> PRIME.
- PRIME:
  - No reads.
  - aud_level >= PRIME_LEVEL and udp_level >= PRIME_LEVEL -> RUN.
  - start=0 -> IDLE.
- RUN, on sample_tick with the sequencer free:
  - Both FIFOs non-empty: next cycle assert aud_rd_en=udp_rd_en=1 for exactly one cycle (paired read).
  - Either FIFO empty: no read; underrun_cnt += 1 (saturate at all-ones); -> STALL.
- Skew correction (only when enabled, see Optional Feature), evaluated at the tick of a paired read:
  - If udp_level > aud_level + SKEW_MAX and udp_level >= 2: the cycle after the paired read asserts udp_rd_en alone; that word is discarded and lms_en stays 0 for it.
  - Symmetric case: aud_level > udp_level + SKEW_MAX and aud_level >= 2 -> aud_rd_en alone.
  - Each drop does drop_cnt += 1 (saturating). At most one drop per tick.
- Sequencer busy window:
  - Busy from the tick until the last strobe of its sequence.
  - Ticks arriving while busy are ignored and not counted.
  - Upstream guarantees tick spacing >= 4 cycles.
- STALL:
  - No reads; lms_en=0; timer increments every cycle.
  - Both levels >= RESUME_LEVEL -> RUN; timer cleared.
  - timer == STALL_TIMEOUT-1 -> FLUSH.
  - start=0 -> IDLE.
  - If exit conditions coincide, priority is start=0, then timeout, then resume.
- FLUSH:
  - lms_clr=1 for exactly one cycle, timer cleared, -> PRIME.
- start=0 in RUN:
  - Any in-flight sequence (paired read plus drop) completes, including its lms_en.
  - Then -> IDLE.
  - No lms_clr.
- Counters:
  - Never wrap; hold at all-ones.
  - Cleared only by reset.
- Simultaneous tick and start falling edge in RUN: the tick is served, then -> IDLE.

Optional Feature:
- Macro LMS_SKEW_CORR_EN.
- When defined: skew-correction drops behave as above.
- When undefined:
  - No single-FIFO reads are ever issued.
  - drop_cnt is constant 0.
  - The sequencer busy window is 2 cycles.

Test Plan:
- Priming:
  - Stimulus: reset, start=1, both levels ramp to 63 -> response: state stays PRIME.
  - Stimulus: both levels reach 64 -> response: RUN next cycle.
  - Stimulus: first tick in RUN -> response: paired rd_en one cycle after the tick; lms_en 2 cycles after the tick.
- Steady run:
  - Stimulus: 100 ticks spaced 8 cycles, levels 200/200 -> response: 100 paired reads, 100 lms_en pulses, underrun_cnt=0, drop_cnt=0.
- Underrun:
  - Stimulus: udp_empty=1 at a tick -> response: no rd_en, underrun_cnt=1, STALL.
  - Stimulus: levels restored to 16/16 -> response: RUN, lms_clr never asserted.
- Timeout flush:
  - Stimulus: hold udp_level=0 for 4096 cycles in STALL -> response: FLUSH, single lms_clr pulse, then PRIME.
- Skew drop (macro defined):
  - Stimulus: aud_level=100, udp_level=140 at a tick -> response: paired read, then udp_rd_en alone next cycle, lms_en only for the pair, drop_cnt=1.
  - Same stimulus with macro undefined -> response: no drop, drop_cnt=0.
- Reset mid-sequence:
  - Stimulus: assert audio_rst in the cycle paired rd_en is high -> response: all outputs 0 immediately, no lms_en afterwards, state IDLE.
